multi_s2f_tx: RTL

- Slow-domain (clka) source stage directly upstream of the slow-to-fast multi-bit synchroniser.
- Accepts words over a valid/ready handshake and buffers them in a small FIFO.
- Presents each word on a registered data bus with a level valid pulse, formatted so the fast side's rising-edge detector samples it exactly once:
  - data stable before valid rises;
  - valid held high for a fixed number of cycles;
  - mandatory low gap before the next word.

---
 rtl/multi_s2f_pkg.sv | 21 ++
 rtl/multi_s2f_fifo.sv | 63 ++++++
 rtl/multi_s2f_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multi_s2f_pkg.sv
// Shared definitions for the slow-to-fast multi-bit synchroniser source stage.
// Holds the FSM state encoding, the default word width and the counter sizing helper.
package multi_s2f_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    // The counter only ever holds (cycles - 1), so the larger window needs $clog2(max) bits.
    function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
        int max_cyc;
        max_cyc = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/multi_s2f_fifo.sv
// Single-clock synchronous FIFO with registered storage and an occupancy count.
// The head entry is always visible on rd_data; rd_en removes it on the clock edge.
module multi_s2f_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clka,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         cnt;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full    = (cnt == LW'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rd_data = mem[rd_ptr];

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clka) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_s2f_tx.sv
// Slow-domain source stage ahead of the slow-to-fast multi-bit synchroniser.
// Buffers upstream words and emits each as stable data plus a fixed-width valid pulse.
module multi_s2f_tx
    import multi_s2f_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_CYC   = 2,
    parameter int GAP_CYC    = 1
) (
    input  logic                            clka,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            valid_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    // state | meaning
    // IDLE  | nothing in flight, valid_out low, waiting for a buffered word
    // LOAD  | head word just popped into dout, valid_out still low for setup
    // HOLD  | valid_out high for HOLD_CYC cycles, dout frozen
    // GAP   | valid_out low for GAP_CYC extra cycles so the fast side sees a clean edge

    localparam int                 CNT_W     = cnt_width(HOLD_CYC, GAP_CYC);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  valid_d;

    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign busy    = !empty || (state_q != IDLE);

    multi_s2f_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka    (clka),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dout      <= '0;
            valid_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout      <= dout_d;
            valid_out <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD: begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP_CYC > 0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else if (!empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!empty) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // dout only moves on LOAD entry, so it is settled a full cycle before valid rises.
    always_comb begin
        valid_d = (state_d == HOLD);
        dout_d  = pop ? head : dout;
    end

endmodule
